// File: rtl/ccg_sweep_ctrl.sv
// ccg_sweep_ctrl: exhaustive-sweep sequencer for a clockless combinational
// netlist. Walks every input vector in ascending order, lets each one settle
// for SETTLE cycles, and folds the captured output word into a MISR signature.
module ccg_sweep_ctrl #(
    parameter int                N_IN   = 7,
    parameter int                N_OUT  = 4,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021,
    parameter int                SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_x,
    input  logic [N_OUT-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic             sig_valid,
    output logic [SIG_W-1:0] signature,
    output logic [N_IN-1:0]  vec_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [SIG_W-1:0]   misr_q, misr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sig_valid_q, sig_valid_d;
    logic [SIG_W-1:0]   f_ext;

    // The DUT output word is zero-extended to the signature width before folding.
    assign f_ext = SIG_W'(dut_f);

    // Sequencing: start/restart, settle counting, capture, and the abort/hold overrides.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        misr_d      = misr_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sig_valid_d = sig_valid_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    vec_d       = '0;
                    misr_d      = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    sig_valid_d = 1'b0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    vec_d       = '0;
                    busy_d      = 1'b0;
                    sig_valid_d = 1'b0;
                end else if (!hold) begin
                    if (cnt_q != SETTLE_C) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        misr_d = {misr_q[SIG_W-2:0], 1'b0}
                               ^ (misr_q[SIG_W-1] ? POLY : '0)
                               ^ f_ext;
                        cnt_d  = '0;
                        if (vec_q == '1) begin
                            state_d     = ST_DONE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            sig_valid_d = 1'b1;
                        end else begin
                            vec_d = vec_q + N_IN'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset back to an idle, cleared sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            misr_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sig_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            misr_q      <= misr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sig_valid_q <= sig_valid_d;
        end
    end

    assign dut_x     = vec_q;
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sig_valid = sig_valid_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// tb_ccg_sweep_ctrl: two sequencers (a tiny 2-input one and a default-sized one)
// are driven by directed scenarios and then random control traffic, and every
// cycle is compared against a sweep model based on elapsed active cycles.
module tb_ccg_sweep_ctrl;

    localparam int NIN_A = 2;
    localparam int NIN_B = 7;
    localparam int SET_A = 1;
    localparam int SET_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, hold_a, abort_a, start_b, hold_b, abort_b;
    logic [1:0]  x_a, f_a, vec_a, mask_a;
    logic [6:0]  x_b, vec_b;
    logic [3:0]  f_b, mask_b;
    logic        zero_b;
    logic        busy_a, done_a, sv_a, busy_b, done_b, sv_b;
    logic [15:0] sig_a, sig_b;

    int checks = 0;
    int errors = 0;

    // Combinational netlists under test: a masked identity and a masked fold.
    assign f_a = x_a ^ mask_a;
    assign f_b = zero_b ? 4'h0 : (x_b[3:0] ^ x_b[6:3] ^ mask_b);

    ccg_sweep_ctrl #(.N_IN(NIN_A), .N_OUT(2), .SIG_W(16), .POLY(16'h1021), .SETTLE(SET_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .hold(hold_a), .abort(abort_a),
        .dut_x(x_a), .dut_f(f_a), .busy(busy_a), .done(done_a),
        .sig_valid(sv_a), .signature(sig_a), .vec_idx(vec_a));

    ccg_sweep_ctrl dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hold(hold_b), .abort(abort_b),
        .dut_x(x_b), .dut_f(f_b), .busy(busy_b), .done(done_b),
        .sig_valid(sv_b), .signature(sig_b), .vec_idx(vec_b));

    // Model state per instance: k counts un-held cycles since the accepted start.
    bit          m_run  [2];
    int          m_k    [2];
    logic [15:0] m_misr [2];
    bit          m_sv   [2];
    bit          m_done [2];
    int          m_x    [2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit sa, input bit ha, input bit aa,
                                 input bit sb, input bit hb, input bit ab);
        rst = r; start_a = sa; hold_a = ha; abort_a = aa;
        start_b = sb; hold_b = hb; abort_b = ab;
        @(negedge clk);
    endtask

    function automatic logic [15:0] misrStep(input logic [15:0] m, input logic [15:0] f);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ f;
    endfunction

    function automatic int modelF(input int i, input int x);
        if (i == 0) return (x & 3) ^ int'(mask_a);
        if (zero_b) return 0;
        return ((x & 15) ^ ((x >> 3) & 15)) ^ int'(mask_b);
    endfunction

    task automatic modelStep(input int i, input bit s, input bit h, input bit a);
        int nin, per, total;
        nin   = (i == 0) ? NIN_A : NIN_B;
        per   = ((i == 0) ? SET_A : SET_B) + 1;
        total = (1 << nin) * per;
        if (rst) begin
            m_run[i] = 0; m_k[i] = 0; m_misr[i] = '0; m_sv[i] = 0; m_done[i] = 0; m_x[i] = 0;
        end else if (m_run[i]) begin
            m_done[i] = 0;
            if (a) begin
                m_run[i] = 0; m_sv[i] = 0; m_x[i] = 0;
            end else if (!h) begin
                if (m_k[i] % per == per - 1)
                    m_misr[i] = misrStep(m_misr[i], 16'(modelF(i, m_x[i])));
                m_k[i]++;
                if (m_k[i] == total) begin
                    m_run[i] = 0; m_done[i] = 1; m_sv[i] = 1; m_x[i] = (1 << nin) - 1;
                end else begin
                    m_x[i] = m_k[i] / per;
                end
            end
        end else begin
            m_done[i] = 0;
            if (s) begin
                m_run[i] = 1; m_k[i] = 0; m_x[i] = 0; m_misr[i] = '0; m_sv[i] = 0;
            end
        end
    endtask

    // Advance the model on the same edge that the sequencers sample their inputs.
    always @(posedge clk) begin
        modelStep(0, start_a, hold_a, abort_a);
        modelStep(1, start_b, hold_b, abort_b);
    end

    // Compare every output of both instances against the model, away from the edge.
    always @(negedge clk) begin
        checkOutput("busyA", busy_a, m_run[0]);
        checkOutput("doneA", done_a, m_done[0]);
        checkOutput("svA", sv_a, m_sv[0]);
        checkOutput("sigA", sig_a, m_misr[0]);
        checkOutput("xA", x_a, m_x[0]);
        checkOutput("vecA", vec_a, m_x[0]);
        checkOutput("busyB", busy_b, m_run[1]);
        checkOutput("doneB", done_b, m_done[1]);
        checkOutput("svB", sv_b, m_sv[1]);
        checkOutput("sigB", sig_b, m_misr[1]);
        checkOutput("xB", x_b, m_x[1]);
        checkOutput("vecB", vec_b, m_x[1]);
    end

    task automatic countBusyA(input int holdFrom, input int holdLen, input int startAt, output int cyc);
        cyc = 0;
        while (busy_a && cyc < 200) begin
            applyStimulus(0, cyc == startAt, (cyc >= holdFrom) && (cyc < holdFrom + holdLen), 0, 0, 0, 0);
            cyc++;
        end
        checkOutput("busyAFell", busy_a, 1'b0);
    endtask

    task automatic runA(input int holdFrom, input int holdLen, input int startAt, output int cyc);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        countBusyA(holdFrom, holdLen, startAt, cyc);
    endtask

    initial begin
        int cyc;
        mask_a = 2'b00; mask_b = 4'h0; zero_b = 1'b0;
        rst = 1'b1;
        start_a = 0; hold_a = 0; abort_a = 0; start_b = 0; hold_b = 0; abort_b = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("rstBusyA", busy_a, 0);
        checkOutput("rstSigA", sig_a, 0);
        checkOutput("rstVecB", vec_b, 0);
        checkOutput("rstSvB", sv_b, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Identity netlist sweep and the done pulse that follows it.
        runA(1000, 0, -1, cyc);
        checkOutput("T1busyLen", cyc, 8);
        checkOutput("T1done", done_a, 1);
        checkOutput("T1sv", sv_a, 1);
        checkOutput("T1sig", sig_a, 16'h0003);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("T1donePulse", done_a, 0);
        checkOutput("T1svHeld", sv_a, 1);
        checkOutput("T1vecHeld", vec_a, 2'b11);

        // Inverted netlist gives a different, hand-derived signature.
        mask_a = 2'b11;
        runA(1000, 0, -1, cyc);
        checkOutput("invSig", sig_a, 16'h0012);
        mask_a = 2'b00;

        // Five held cycles stretch the sweep without changing the signature.
        runA(2, 5, -1, cyc);
        checkOutput("T3busyLen", cyc, 13);
        checkOutput("T3sig", sig_a, 16'h0003);

        // Abort mid-sweep, then a clean sweep afterwards.
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        checkOutput("T4busy", busy_a, 0);
        checkOutput("T4done", done_a, 0);
        checkOutput("T4sv", sv_a, 0);
        checkOutput("T4x", x_a, 0);
        runA(1000, 0, -1, cyc);
        checkOutput("T4sig", sig_a, 16'h0003);

        // Start while busy is ignored; start in the DONE cycle restarts.
        runA(1000, 0, 3, cyc);
        checkOutput("T5busyLen", cyc, 8);
        checkOutput("T5done", done_a, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("T5restartBusy", busy_a, 1);
        checkOutput("T5restartSv", sv_a, 0);
        countBusyA(1000, 0, -1, cyc);
        checkOutput("T5busyLen2", cyc, 8);
        checkOutput("T5sig", sig_a, 16'h0003);

        // Reset mid-sweep on both instances.
        applyStimulus(0, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("T6busyA", busy_a, 0);
        checkOutput("T6xA", x_a, 0);
        checkOutput("T6busyB", busy_b, 0);
        checkOutput("T6vecB", vec_b, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        runA(1000, 0, -1, cyc);
        checkOutput("T6sig", sig_a, 16'h0003);

        // Default-sized sweep with the netlist tied low.
        zero_b = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        cyc = 0;
        while (busy_b && cyc < 400) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            cyc++;
        end
        checkOutput("T2busyLen", cyc, 256);
        checkOutput("T2sig", sig_b, 16'h0000);
        checkOutput("T2vec", vec_b, 7'h7F);
        checkOutput("T2done", done_b, 1);
        zero_b = 1'b0;

        // Random control traffic on both instances.
        for (int n = 0; n < 8000; n++) begin
            if (n % 64 == 0) begin
                mask_a = 2'($urandom_range(0, 3));
                mask_b = 4'($urandom_range(0, 15));
            end
            applyStimulus($urandom_range(0, 1999) == 0,
                          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
                          $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, $urandom_range(0, 999) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
